// File: rtl/eth_tx_min_pad.sv
`default_nettype none
// ============================================================================
//  Module      : eth_tx_min_pad
//  Description : Transmit-side minimum frame length enforcer. Frames shorter
//                than MIN_FRAME_BYTES get their tail bytes zeroed, extra
//                all-zero beats appended where needed, and a corrected frame
//                size. Longer frames pass through with zero added latency.
//  Ports       : clk, rst                - clock, synchronous active-high reset
//                src_pad_*               - input stream (val/rdy handshake)
//                pad_src_data_rdy        - input ready
//                pad_dst_*               - output stream
//                dst_pad_data_rdy        - output ready
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_min_pad #(
    parameter int DATA_W          = 256,
    parameter int PADBYTES_W      = $clog2(DATA_W / 8),
    parameter int SIZE_W          = 14,
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src_pad_data_val,
    input  logic                  src_pad_startframe,
    input  logic [DATA_W-1:0]     src_pad_data,
    input  logic [SIZE_W-1:0]     src_pad_frame_size,
    input  logic                  src_pad_endframe,
    input  logic [PADBYTES_W-1:0] src_pad_data_padbytes,
    output logic                  pad_src_data_rdy,
    output logic                  pad_dst_data_val,
    output logic                  pad_dst_startframe,
    output logic [DATA_W-1:0]     pad_dst_data,
    output logic [SIZE_W-1:0]     pad_dst_frame_size,
    output logic                  pad_dst_endframe,
    output logic [PADBYTES_W-1:0] pad_dst_data_padbytes,
    input  logic                  dst_pad_data_rdy
);

    localparam int DATA_BYTES = DATA_W / 8;
    // One extra bit so base + beat bytes never wraps.
    localparam int SUM_W      = SIZE_W + 1;

    localparam logic [SUM_W-1:0]  c_DBYTES   = SUM_W'(DATA_BYTES);
    localparam logic [SUM_W-1:0]  c_MIN      = SUM_W'(MIN_FRAME_BYTES);
    localparam logic [SIZE_W-1:0] c_MIN_SIZE = SIZE_W'(MIN_FRAME_BYTES);

    typedef enum logic [0:0] {
        ST_PASS = 1'b0,
        ST_PAD  = 1'b1
    } state_t;

    state_t            state_reg;
    logic [SIZE_W-1:0] cnt_reg;
    logic [SUM_W-1:0]  rem_reg;
    logic [SIZE_W-1:0] size_reg;

    logic                  w_pass;
    logic                  w_src_xfer;
    logic [SUM_W-1:0]      w_pad_ext;
    logic [SUM_W-1:0]      w_base;
    logic [SUM_W-1:0]      w_beat_bytes;
    logic [SUM_W-1:0]      w_sum;
    logic                  w_short;
    logic [SUM_W-1:0]      w_need;
    logic                  w_need_fits;
    logic                  w_rem_fits;
    logic [SIZE_W-1:0]     w_size_max;
    logic [DATA_BYTES-1:0] w_keep;

    assign w_pass           = (state_reg == ST_PASS);
    assign pad_src_data_rdy = !rst && w_pass && dst_pad_data_rdy;
    assign pad_dst_data_val = !rst && (w_pass ? src_pad_data_val : 1'b1);
    assign w_src_xfer       = src_pad_data_val && pad_src_data_rdy;

    assign w_pad_ext    = SUM_W'(src_pad_data_padbytes);
    assign w_base       = src_pad_startframe ? '0 : SUM_W'(cnt_reg);
    assign w_beat_bytes = src_pad_endframe ? (c_DBYTES - w_pad_ext) : c_DBYTES;
    assign w_sum        = w_base + w_beat_bytes;
    // A short last beat: frame ends before reaching the minimum length.
    assign w_short      = src_pad_endframe && (w_sum < c_MIN);
    assign w_need       = c_MIN - w_base;
    assign w_need_fits  = (w_need <= c_DBYTES);
    assign w_rem_fits   = (rem_reg <= c_DBYTES);
    assign w_size_max   = (src_pad_frame_size < c_MIN_SIZE) ? c_MIN_SIZE
                                                            : src_pad_frame_size;

    // Byte i sits at the MSB end; on a short beat every byte past the valid
    // ones is forced to zero so the pad region carries zeros.
    for (genvar i = 0; i < DATA_BYTES; i++) begin : g_keep
        assign w_keep[i] = !w_short || (w_beat_bytes > SUM_W'(i));
        assign pad_dst_data[DATA_W-1-8*i -: 8] =
            (w_pass && w_keep[i]) ? src_pad_data[DATA_W-1-8*i -: 8] : 8'h00;
    end

    always_comb begin
        pad_dst_startframe    = 1'b0;
        pad_dst_endframe      = 1'b0;
        pad_dst_data_padbytes = '0;
        pad_dst_frame_size    = size_reg;
        if (w_pass) begin
            pad_dst_startframe = src_pad_startframe;
            if (src_pad_startframe) begin
                pad_dst_frame_size = w_size_max;
            end
            if (w_short) begin
                pad_dst_endframe = w_need_fits;
                if (w_need_fits) begin
                    pad_dst_data_padbytes = PADBYTES_W'(c_DBYTES - w_need);
                end
            end else begin
                pad_dst_endframe = src_pad_endframe;
                if (src_pad_endframe) begin
                    pad_dst_data_padbytes = src_pad_data_padbytes;
                end
            end
        end else begin
            pad_dst_endframe = w_rem_fits;
            if (w_rem_fits) begin
                pad_dst_data_padbytes = PADBYTES_W'(c_DBYTES - rem_reg);
            end
        end
        // Framing sidebands are held at zero whenever no beat is offered.
        if (!pad_dst_data_val) begin
            pad_dst_startframe    = 1'b0;
            pad_dst_endframe      = 1'b0;
            pad_dst_data_padbytes = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_PASS;
            cnt_reg   <= '0;
            rem_reg   <= '0;
            size_reg  <= '0;
        end else begin
            case (state_reg)
                ST_PASS: begin
                    if (w_src_xfer) begin
                        cnt_reg <= (w_sum >= c_MIN) ? c_MIN_SIZE : SIZE_W'(w_sum);
                        if (src_pad_startframe) begin
                            size_reg <= w_size_max;
                        end
                        if (w_short && !w_need_fits) begin
                            rem_reg   <= w_need - c_DBYTES;
                            state_reg <= ST_PAD;
                        end
                    end
                end
                ST_PAD: begin
                    if (dst_pad_data_rdy) begin
                        if (w_rem_fits) begin
                            state_reg <= ST_PASS;
                        end else begin
                            rem_reg <= rem_reg - c_DBYTES;
                        end
                    end
                end
                default: state_reg <= ST_PASS;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_min_pad.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_tx_min_pad
//  Description : Directed, table-driven bench for eth_tx_min_pad with
//                DATA_W = 256 and MIN_FRAME_BYTES = 60.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_tx_min_pad;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_val, s_sf, s_ef;
    logic [255:0] s_data;
    logic [13:0]  s_size;
    logic [4:0]   s_pad;
    logic         s_rdy;
    logic         d_val, d_sf, d_ef;
    logic [255:0] d_data;
    logic [13:0]  d_size;
    logic [4:0]   d_pad;
    logic         d_rdy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    eth_tx_min_pad #(
        .DATA_W(256), .PADBYTES_W(5), .SIZE_W(14), .MIN_FRAME_BYTES(60)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .src_pad_data_val      (s_val),
        .src_pad_startframe    (s_sf),
        .src_pad_data          (s_data),
        .src_pad_frame_size    (s_size),
        .src_pad_endframe      (s_ef),
        .src_pad_data_padbytes (s_pad),
        .pad_src_data_rdy      (s_rdy),
        .pad_dst_data_val      (d_val),
        .pad_dst_startframe    (d_sf),
        .pad_dst_data          (d_data),
        .pad_dst_frame_size    (d_size),
        .pad_dst_endframe      (d_ef),
        .pad_dst_data_padbytes (d_pad),
        .dst_pad_data_rdy      (d_rdy)
    );

    typedef struct packed {
        logic         rst, val, sf, ef;
        logic [4:0]   pad;
        logic [255:0] data;
        logic [13:0]  size;
        logic         drdy;
        logic         e_val, e_rdy, e_sf, e_ef;
        logic [4:0]   e_pad;
        logic [255:0] e_data;
        logic [13:0]  e_size;
    } vec_t;

    vec_t vq[$];

    // Non-zero byte pattern; byte 0 is at the MSBs.
    function automatic logic [255:0] pat(input logic [7:0] seed);
        logic [255:0] d;
        for (int i = 0; i < 32; i++) d[255-8*i -: 8] = 8'h80 | 8'(seed + 8'(i));
        return d;
    endfunction

    function automatic logic [255:0] zero_from(input logic [255:0] d, input int n);
        logic [255:0] r = d;
        for (int i = n; i < 32; i++) r[255-8*i -: 8] = 8'h00;
        return r;
    endfunction

    function automatic vec_t mk(
        input logic r, v, sf, ef, input logic [4:0] pd, input logic [255:0] dt,
        input logic [13:0] sz, input logic dr,
        input logic ev, er, esf, eef, input logic [4:0] epd,
        input logic [255:0] edt, input logic [13:0] esz);
        vec_t x;
        x.rst = r; x.val = v; x.sf = sf; x.ef = ef; x.pad = pd; x.data = dt;
        x.size = sz; x.drdy = dr; x.e_val = ev; x.e_rdy = er; x.e_sf = esf;
        x.e_ef = eef; x.e_pad = epd; x.e_data = edt; x.e_size = esz;
        return x;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL v%0d %s: got %h expected %h", idx, name, got, exp);
        end
    endtask

    task automatic drive(input logic r, v, sf, ef, input logic [4:0] pd,
                         input logic [255:0] dt, input logic [13:0] sz, input logic dr);
        rst = r; s_val = v; s_sf = sf; s_ef = ef; s_pad = pd;
        s_data = dt; s_size = sz; d_rdy = dr;
    endtask

    logic [255:0] Z;
    logic         got_rdy;

    initial begin
        Z = '0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, Z, 14'd0, 1'b0);

        // 0: reset blocks both handshakes
        vq.push_back(mk(1,1,1,0, 0, pat(8'h01), 64, 1,  0,0,0,0, 0, Z, 0));
        // 1-2: 64-byte frame passes unchanged
        vq.push_back(mk(0,1,1,0, 0, pat(8'h10), 64, 1,  1,1,1,0, 0, pat(8'h10), 64));
        vq.push_back(mk(0,1,0,1, 0, pat(8'h20),  0, 1,  1,1,0,1, 0, pat(8'h20), 64));
        // 3-4: exactly 60 bytes passes unchanged
        vq.push_back(mk(0,1,1,0, 0, pat(8'h30), 60, 1,  1,1,1,0, 0, pat(8'h30), 60));
        vq.push_back(mk(0,1,0,1, 4, pat(8'h40),  0, 1,  1,1,0,1, 4, pat(8'h40), 60));
        // 5-6: 42-byte frame, tail zeroed, padbytes 4
        vq.push_back(mk(0,1,1,0, 0, pat(8'h50), 42, 1,  1,1,1,0, 0, pat(8'h50), 60));
        vq.push_back(mk(0,1,0,1,22, pat(8'h60),  0, 1,  1,1,0,1, 4, zero_from(pat(8'h60),10), 60));
        // 7-8: 14-byte single beat, then one PAD beat
        vq.push_back(mk(0,1,1,1,18, pat(8'h70), 14, 1,  1,1,1,0, 0, zero_from(pat(8'h70),14), 60));
        vq.push_back(mk(0,0,0,0, 0, Z,           0, 1,  1,0,0,1, 4, Z, 60));
        // 9-15: 14-byte frame, PAD stalled 3 cycles while next frame waits
        vq.push_back(mk(0,1,1,1,18, pat(8'h11), 14, 1,  1,1,1,0, 0, zero_from(pat(8'h11),14), 60));
        vq.push_back(mk(0,1,1,0, 0, pat(8'h21), 64, 0,  1,0,0,1, 4, Z, 60));
        vq.push_back(mk(0,1,1,0, 0, pat(8'h21), 64, 0,  1,0,0,1, 4, Z, 60));
        vq.push_back(mk(0,1,1,0, 0, pat(8'h21), 64, 0,  1,0,0,1, 4, Z, 60));
        vq.push_back(mk(0,1,1,0, 0, pat(8'h21), 64, 1,  1,0,0,1, 4, Z, 60));
        vq.push_back(mk(0,1,1,0, 0, pat(8'h21), 64, 1,  1,1,1,0, 0, pat(8'h21), 64));
        vq.push_back(mk(0,1,0,1, 0, pat(8'h31),  0, 1,  1,1,0,1, 0, pat(8'h31), 64));
        // 16-20: reset while in PAD, then a 42-byte frame, no leftover beat
        vq.push_back(mk(0,1,1,1,18, pat(8'h41), 14, 1,  1,1,1,0, 0, zero_from(pat(8'h41),14), 60));
        vq.push_back(mk(1,0,0,0, 0, Z,           0, 1,  0,0,0,0, 0, Z, 0));
        vq.push_back(mk(0,1,1,0, 0, pat(8'h51), 42, 1,  1,1,1,0, 0, pat(8'h51), 60));
        vq.push_back(mk(0,1,0,1,22, pat(8'h61),  0, 1,  1,1,0,1, 4, zero_from(pat(8'h61),10), 60));
        vq.push_back(mk(0,0,0,0, 0, Z,           0, 1,  0,1,0,0, 0, Z, 0));
        // 21-23: startframe without endframe, new frame restarts the count
        vq.push_back(mk(0,1,1,0, 0, pat(8'h71),100, 1,  1,1,1,0, 0, pat(8'h71), 100));
        vq.push_back(mk(0,1,1,1,18, pat(8'h12), 14, 1,  1,1,1,0, 0, zero_from(pat(8'h12),14), 60));
        vq.push_back(mk(0,0,0,0, 0, Z,           0, 1,  1,0,0,1, 4, Z, 60));

        for (int k = 0; k < vq.size(); k++) begin
            @(posedge clk); #1;
            drive(vq[k].rst, vq[k].val, vq[k].sf, vq[k].ef, vq[k].pad,
                  vq[k].data, vq[k].size, vq[k].drdy);
            @(negedge clk);
            chk("val", k, 256'(d_val), 256'(vq[k].e_val));
            chk("src_rdy", k, 256'(s_rdy), 256'(vq[k].e_rdy));
            chk("startframe", k, 256'(d_sf), 256'(vq[k].e_sf));
            chk("endframe", k, 256'(d_ef), 256'(vq[k].e_ef));
            chk("padbytes", k, 256'(d_pad), 256'(vq[k].e_pad));
            if (vq[k].e_val) begin
                chk("data", k, d_data, vq[k].e_data);
                chk("frame_size", k, 256'(d_size), 256'(vq[k].e_size));
            end
        end

        // Hand sequence: PASS beat under back-pressure, bounded wait for accept.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, pat(8'h22), 14'd80, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("stall_val", 100 + c, 256'(d_val), 256'(1'b1));
            chk("stall_rdy", 100 + c, 256'(s_rdy), 256'(1'b0));
            chk("stall_data", 100 + c, d_data, pat(8'h22));
            @(posedge clk); #1;
        end
        d_rdy = 1'b1;
        got_rdy = 1'b0;
        for (int c = 0; c < 5 && !got_rdy; c++) begin
            @(negedge clk);
            if (s_rdy) got_rdy = 1'b1;
        end
        chk("accept_timeout", 102, 256'(got_rdy), 256'(1'b1));
        chk("accept_size", 102, 256'(d_size), 256'(14'd80));
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, Z, 14'd0, 1'b1);
        @(negedge clk);
        chk("idle_val", 103, 256'(d_val), 256'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_tx_min_pad.md
# eth_tx_min_pad

Transmit-side stage that enforces the Ethernet minimum frame length (60 bytes, excluding FCS) on the MAC-width stream built from an Ethernet header plus payload. It sits directly downstream of the header-to-stream stage and upstream of the MAC/FCS stage. Frames shorter than the minimum get zero bytes appended, extra all-zero beats where needed, and a corrected frame size. Longer frames pass through unchanged with zero added latency.

## Interface
Parameters:
- DATA_W, 256: stream width in bits; DATA_BYTES = DATA_W/8.
- PADBYTES_W, $clog2(DATA_BYTES): width of the padbytes field.
- SIZE_W, 14: frame size width in bytes.
- MIN_FRAME_BYTES, 60: minimum frame length in bytes. Must be ≥ 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- src_pad_data_val  in  1  input beat valid
- src_pad_startframe  in  1  first beat of frame
- src_pad_data  in  DATA_W  beat data; byte 0 at the MSBs
- src_pad_frame_size  in  SIZE_W  frame length in bytes; sampled on the startframe beat
- src_pad_endframe  in  1  last beat of frame
- src_pad_data_padbytes  in  PADBYTES_W  invalid LSB-end bytes on the last beat
- pad_src_data_rdy  out  1  input ready
- pad_dst_data_val, pad_dst_startframe, pad_dst_data, pad_dst_frame_size, pad_dst_endframe, pad_dst_data_padbytes  out  same widths  output stream
- dst_pad_data_rdy  in  1  output ready

## Operation
- **Beat transfer:** a beat transfers when val & rdy on that side.
- **Padbytes scope:** input padbytes is meaningful only when endframe = 1.
- **States:** PASS (reset state) and PAD.
- **PASS state:**
  - pad_dst_data_val = src_pad_data_val and pad_src_data_rdy = dst_pad_data_rdy, both combinational.
  - startframe passes through unchanged.
- **Byte counter cnt_reg** (SIZE_W, saturating at MIN_FRAME_BYTES):
  - On a transferred startframe beat, counting restarts from 0 before the beat is added.
  - Beat bytes = DATA_BYTES − padbytes if endframe, else DATA_BYTES.
  - On a transferred beat, cnt_next = min(base + beat bytes, MIN_FRAME_BYTES), where base = 0 on a startframe beat, else cnt_reg.
- **Output frame size:** pad_dst_frame_size = max(src_pad_frame_size, MIN_FRAME_BYTES).
  - Computed combinationally on the startframe beat.
  - Latched into size_reg on that beat's transfer and driven from size_reg on all later beats of the frame, including PAD beats.
- **Last input beat with base + beat bytes ≥ MIN:** passed unmodified (data, padbytes, endframe).
- **Last input beat with base + beat bytes < MIN:** let need = MIN − base. All bytes after the valid bytes are forced to zero.
  - If need ≤ DATA_BYTES: output endframe = 1, padbytes = DATA_BYTES − need; remain in PASS.
  - Else: output endframe = 0, padbytes = 0. On transfer, load rem_reg = need − DATA_BYTES and go to PAD.
- **PAD state:**
  - pad_src_data_rdy = 0, pad_dst_data_val = 1, data = 0, startframe = 0.
  - endframe = (rem_reg ≤ DATA_BYTES), with padbytes = DATA_BYTES − rem_reg on that beat, else 0.
  - On a non-final transfer, rem_reg −= DATA_BYTES.
  - On the final transfer, go to PASS.
- **Startframe without preceding endframe:** treated as a new frame; the counter restarts.
- **Single-beat frames:** startframe and endframe together are legal.

## Timing
- **Latency:** PASS is a 0-cycle combinational path. Each PAD beat takes one cycle when dst ready is high.
- **Output stability:** a PAD beat is held stable while dst_pad_data_rdy = 0. A PASS beat is stable because the input must hold it under the valid/ready protocol.
- **While rst = 1:**
  - pad_dst_data_val = 0 and pad_src_data_rdy = 0.
  - The next state is PASS with cnt_reg = 0, rem_reg = 0, size_reg = 0.
- **Outputs following reset:** startframe, endframe and padbytes are 0 when val = 0. Data and frame_size are don't-care when val = 0.
- **Reset in PAD:** the padding beats are abandoned. The first cycle after reset is PASS with val following the input.
- **Frame boundary after padding:** no bubble is inserted on entry to PASS. A new frame is accepted in the same cycle as the final PAD transfer + 1.

## Test plan
All scenarios use DATA_W = 256 (32 bytes) and MIN = 60.
- 64-byte frame (2 beats, padbytes 0, size 64) -> output identical to input, frame_size 64, no extra beats, same-cycle pass-through.
- Exactly 60-byte frame (2nd beat padbytes 4) -> unchanged output, frame_size 60.
- 42-byte frame (beat 2 padbytes 22, beat 2 bytes 10–31 non-zero garbage) -> beat 2 bytes 10–27 zeroed, padbytes 4, endframe on beat 2, frame_size 60.
- 14-byte single-beat frame (padbytes 18) -> beat 1 with bytes 14–31 zeroed and endframe 0, then a PAD beat of all zeros with padbytes 4 and endframe 1; src rdy low during PAD; frame_size 60 on both beats.
- Back-to-back: 14-byte frame then a 64-byte frame with dst_rdy low for 3 cycles during the PAD beat -> PAD beat held stable; the next frame's first beat is not accepted until the cycle after the PAD transfer; the second frame passes unchanged.
- Assert rst for 1 cycle while in PAD -> val 0 during reset; the next 42-byte frame is padded correctly with no leftover PAD beat.
